// File: rtl/fp_cmp_arb.sv
// fp_cmp_arb: round-robin arbiter and two-stage sequencer that shares one
// fp_cmp comparator among NREQ requesters.
//
// Ports:
//   clock, reset      single clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_data1/2       65-bit operands per requester (bit 64 = sign)
//   req_rm            op select per requester (0 fle, 1 flt, 2 feq)
//   req_class1/2      10-bit class vectors per requester
//   req_tag           opaque tag per requester
//   cmp_i / cmp_o     comparator request (from S1) / comparator result
//   resp_*            single backpressured response channel
//
// Optional build macro FP_CMP_ARB_FLAGS_ACC_EN adds flags_clr / flags_acc,
// a sticky OR of resp_flags over completed response handshakes.

package fp_cmp_pkg;
    typedef struct packed {
        logic [64:0] data1;
        logic [64:0] data2;
        logic [2:0]  rm;
        logic [9:0]  class1;
        logic [9:0]  class2;
    } fp_cmp_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
    } fp_cmp_out_type;
endpackage

module fp_cmp_arb
    import fp_cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 4,
    parameter int IDW  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*65-1:0]   req_data1,
    input  logic [NREQ*65-1:0]   req_data2,
    input  logic [NREQ*3-1:0]    req_rm,
    input  logic [NREQ*10-1:0]   req_class1,
    input  logic [NREQ*10-1:0]   req_class2,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output fp_cmp_in_type        cmp_i,
    input  fp_cmp_out_type       cmp_o,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [TAGW-1:0]      resp_tag,
    output logic [63:0]          resp_result,
    output logic [4:0]           resp_flags
`ifdef FP_CMP_ARB_FLAGS_ACC_EN
    ,
    input  logic                 flags_clr,
    output logic [4:0]           flags_acc
`endif
);

    if (IDW != $clog2(NREQ)) begin : g_bad_idw
        $error("fp_cmp_arb: IDW must equal $clog2(NREQ)");
    end

    typedef struct packed {
        fp_cmp_in_type   op;
        logic [IDW-1:0]  id;
        logic [TAGW-1:0] tag;
    } s1_t;

    typedef struct packed {
        fp_cmp_out_type  res;
        logic [IDW-1:0]  id;
        logic [TAGW-1:0] tag;
    } s2_t;

    logic           s1_valid_q, s1_valid_d;
    logic           s2_valid_q, s2_valid_d;
    s1_t            s1_q, s1_d;
    s2_t            s2_q, s2_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic           s1_adv, s2_adv, accept;
    logic           grant_any;
    logic [IDW-1:0] grant_idx, cand;
    logic [IDW:0]   sum;
    s1_t            sel;

    assign s2_adv = ~s2_valid_q | resp_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;
    assign accept = grant_any & s1_adv;

    // Circular search starting one past the last grant. rr_ptr < NREQ and
    // the offset is <= NREQ, so a single conditional subtract wraps it.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel.op.data1  = req_data1[i*65 +: 65];
                sel.op.data2  = req_data2[i*65 +: 65];
                sel.op.rm     = req_rm[i*3 +: 3];
                sel.op.class1 = req_class1[i*10 +: 10];
                sel.op.class2 = req_class2[i*10 +: 10];
                sel.id        = IDW'(i);
                sel.tag       = req_tag[i*TAGW +: TAGW];
            end
        end
    end

    // Held low while reset is asserted so no requester sees an accept.
    always_comb begin
        req_ready = '0;
        if (reset && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        rr_ptr_d   = rr_ptr_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.res = cmp_o;
                s2_d.id  = s1_q.id;
                s2_d.tag = s1_q.tag;
            end
        end
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_d     = sel;
                rr_ptr_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            rr_ptr_q   <= IDW'(NREQ - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign cmp_i       = s1_q.op;
    assign resp_valid  = s2_valid_q;
    assign resp_id     = s2_q.id;
    assign resp_tag    = s2_q.tag;
    assign resp_result = s2_q.res.result;
    assign resp_flags  = s2_q.res.flags;

`ifdef FP_CMP_ARB_FLAGS_ACC_EN
    logic [4:0] flags_acc_q, flags_acc_d;

    // Clear and a same-cycle handshake: the handshake's flags survive.
    always_comb begin
        flags_acc_d = flags_clr ? 5'h00 : flags_acc_q;
        if (resp_valid && resp_ready) begin
            flags_acc_d = flags_acc_d | resp_flags;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags_acc_q <= '0;
        end else begin
            flags_acc_q <= flags_acc_d;
        end
    end

    assign flags_acc = flags_acc_q;
`endif

endmodule

// File: doc/fp_cmp_arb.md
Name: fp_cmp_arb

Overview:
- Round-robin arbiter and two-stage sequencer that shares one fp_cmp comparator among NREQ requesters, e.g. integer-pipe lanes and the vector compare unit.
- Accepts compare requests (operands, rm, class vectors, tag), drives the comparator from a registered operand stage, and registers the result.
- Returns the result on a single backpressured response channel tagged with the requester index.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 4, width of the opaque per-request tag returned with the response.
- IDW, 2, width of requester index; must equal clog2(NREQ), checked by elaboration assertion.

Ports:
- reset  input  1  asynchronous, active-low reset.
- clock  input  1  single clock; all state updates on its rising edge.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_data1  input  NREQ*65  operand 1 per requester; bit 64 is sign.
- req_data2  input  NREQ*65  operand 2 per requester.
- req_rm  input  NREQ*3  op select: 0 fle, 1 flt, 2 feq.
- req_class1  input  NREQ*10  class vector of operand 1; bit 8 sNaN, bit 9 qNaN, bits 3/4 -0/+0.
- req_class2  input  NREQ*10  class vector of operand 2.
- req_tag  input  NREQ*TAGW  opaque tag.
- cmp_i  output  fp_cmp_in_type  to comparator: data1, data2, rm, class1, class2.
- cmp_o  input  fp_cmp_out_type  from comparator: result[63:0], flags[4:0].
- resp_valid  output  1  response valid.
- resp_ready  input  1  response accept.
- resp_id  output  IDW  index of requester that issued this response.
- resp_tag  output  TAGW  echoed tag.
- resp_result  output  64  comparator result; only bit 0 may be set.
- resp_flags  output  5  comparator flags; bit 4 NV.

Behaviour:
- Reset, asynchronous assert: s1_valid=0, s2_valid=0, rr_ptr=NREQ-1, resp_valid=0, resp_id/resp_tag/resp_result/resp_flags=0, req_ready=0, cmp_i all zero.
- Two registered stages.
  - S1 holds operands, rm, class, id, tag. cmp_i is driven combinationally from S1 only, never from request inputs.
  - S2 is the output register, capturing cmp_o, id, tag.
- Stage advance rules:
  - s2_adv = ~s2_valid | resp_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - Accept allowed iff s1_adv.
- Arbitration: among asserted req_valid, grant the first index searched circularly from rr_ptr+1.
  - req_ready[g]=1 only for the granted index and only when s1_adv; req_ready is combinational from req_valid and state.
  - On accept, rr_ptr <= g. rr_ptr is unchanged when nothing is accepted.
- Latency: accept in cycle N gives resp_valid in cycle N+2. Throughput is 1 per cycle while resp_ready=1.
- Stall, s2_valid & ~resp_ready:
  - S2 holds and resp_* are stable.
  - S1 holds if valid. If S1 is empty, one new accept may fill it.
  - cmp_i remains stable while S1 holds.
- Simultaneous resp_ready handshake and S1 valid: S2 reloads from S1 in the same edge with no bubble.
- rm values 3..7 are passed through. The comparator returns result=0, flags=0, and the response still completes.
- Ordering: responses leave in acceptance order. Each accepted request yields exactly one response.
- req_valid may drop without a handshake. The arbiter must not latch a stale request.
- Reset mid-operation: in-flight S1/S2 entries are discarded with no response, and rr_ptr returns to NREQ-1.

Optional Feature:
- Macro: FP_CMP_ARB_FLAGS_ACC_EN.
- Defined:
  - Adds input flags_clr (1) and output flags_acc (5).
  - flags_acc is a sticky OR of resp_flags over every completed response handshake (resp_valid & resp_ready).
  - flags_clr=1 clears flags_acc. A same-cycle handshake still ORs in, so the new value is that response's flags.
  - Reset value of flags_acc is 0.
- Undefined: ports and logic absent; other behaviour identical.

Test Plan:
- Reset then single request:
  - Stimulus: requester 2, rm=1 (flt), data1=0x0_3FF0000000000000, data2=0x0_4000000000000000, classes normal, tag=5.
  - Required: resp_valid 2 cycles after accept with resp_result=1, flags=0, resp_id=2, resp_tag=5.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, resp_ready=1.
  - Required: grant order 0,1,2,3,0,1…, one accept per cycle, responses in the same order.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles with 3 requests pending.
  - Required: exactly 2 accepted (S1, S2 full); resp_* stable; after release, no loss or duplication and order kept.
- NaN handling:
  - Stimulus: rm=2 (feq) with class1[8]=1 (sNaN), then rm=0 (fle) with class2[9]=1.
  - Required: both return result=0, flags=0x10. With FP_CMP_ARB_FLAGS_ACC_EN, flags_acc=0x10 until flags_clr.
- Signed zero:
  - Stimulus: rm=2 (feq) with -0 and +0 (class bits 3 and 4).
  - Required: result=1, flags=0.
- Reset mid-flight:
  - Stimulus: assert reset with S1 and S2 valid.
  - Required: resp_valid=0 immediately (asynchronous). After release, the first grant goes to requester 0.
